// File: rtl/digi_src_pkg.sv
// digi_src_pkg: shared types and helpers for the digital pattern source.
//   state_t     - playback state (IDLE, RUN, FIN)
//   INIT_LEVEL  - default idle output level
//   clamp_len() - limits a requested pattern length to the pattern width
package digi_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic INIT_LEVEL = 1'b0;

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/digi_pattern_src_hold_counter.sv
// hold_counter: free-running 0..limit counter with a terminal-count flag.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - synchronous return to zero (wins over enable)
//   enable     - advance the count; wraps to zero after reaching limit
//   limit      - terminal value; the period is limit+1 enabled clocks
//   tc         - high while the count equals limit
module hold_counter #(
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [HOLD_W-1:0] limit,
  output logic              tc
);

  logic [HOLD_W-1:0] cnt;

  assign tc = (cnt == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/digi_pattern_src.sv
// digi_pattern_src: plays a stored bit pattern LSB-first onto a single logic
// stream, holding each bit for hold+1 clocks, one-shot or repeating.
//   clk, rst_n           - clock, asynchronous active-low reset
//   load                 - capture pat_in/len_in/hold_in (IDLE only)
//   pat_in, len_in       - pattern (bit 0 first) and length (clamped to WIDTH)
//   hold_in              - per-bit hold; each bit lasts hold_in+1 clocks
//   start, stop          - begin playback (IDLE only) / abort playback
//   repeat_en            - wrap to bit 0 at the end instead of finishing
//   y                    - registered output stream
//   busy, done, bit_idx  - running flag, completion pulse, current bit index
module digi_pattern_src
  import digi_src_pkg::*;
#(
  parameter int   WIDTH  = 16,
  parameter int   LEN_W  = 5,
  parameter int   HOLD_W = 8,
  parameter logic INIT   = INIT_LEVEL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WIDTH-1:0]  pat_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [HOLD_W-1:0] hold_in,
  input  logic              start,
  input  logic              stop,
  input  logic              repeat_en,
  output logic              y,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  bit_idx
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t            state;
  logic [WIDTH-1:0]  pat_r;
  logic [LEN_W-1:0]  len_r;
  logic [HOLD_W-1:0] hold_r;

  logic [LEN_W-1:0]  len_clamped;
  logic [LEN_W-1:0]  eff_len;
  logic              eff_bit0;
  logic [LEN_W-1:0]  next_idx;
  logic              last_bit;
  logic              tc;

  // A simultaneous load+start must launch with the values being loaded.
  always_comb begin
    len_clamped = LEN_W'(clamp_len(32'(len_in), 32'(WIDTH)));
    eff_len     = load ? len_clamped : len_r;
    eff_bit0    = load ? pat_in[0]   : pat_r[0];
    next_idx    = bit_idx + 1'b1;
    last_bit    = (bit_idx == (len_r - 1'b1));
  end

  // Counter idles at zero outside RUN so every run starts on a full hold.
  hold_counter #(.HOLD_W(HOLD_W)) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((state != ST_RUN) || stop),
    .enable (state == ST_RUN),
    .limit  (hold_r),
    .tc     (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      y       <= INIT;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_idx <= '0;
      pat_r   <= '0;
      len_r   <= '0;
      hold_r  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            pat_r  <= pat_in;
            len_r  <= len_clamped;
            hold_r <= hold_in;
          end
          if (start && (eff_len != '0)) begin
            state   <= ST_RUN;
            y       <= eff_bit0;
            busy    <= 1'b1;
            bit_idx <= '0;
          end
        end
        ST_RUN: begin
          // stop outranks the end-of-pattern decision
          if (stop) begin
            state   <= ST_IDLE;
            y       <= INIT;
            busy    <= 1'b0;
            bit_idx <= '0;
          end else if (tc) begin
            if (!last_bit) begin
              bit_idx <= next_idx;
              y       <= pat_r[next_idx[IDX_W-1:0]];
            end else if (repeat_en) begin
              bit_idx <= '0;
              y       <= pat_r[0];
            end else begin
              state   <= ST_FIN;
              y       <= INIT;
              busy    <= 1'b0;
              done    <= 1'b1;
              bit_idx <= '0;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digi_pattern_src.sv
// Testbench for digi_pattern_src: directed scenarios plus randomized traffic,
// checked every cycle against a model that expands the loaded pattern into
// the per-cycle sequence of (level, index) the stream should show.
module tb_digi_pattern_src;

  localparam int   WIDTH  = 16;
  localparam int   LEN_W  = 5;
  localparam int   HOLD_W = 8;
  localparam logic INIT   = 1'b0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              repeat_en = 1'b0;
  logic [WIDTH-1:0]  pat_in = '0;
  logic [LEN_W-1:0]  len_in = '0;
  logic [HOLD_W-1:0] hold_in = '0;
  logic              y;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  bit_idx;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  digi_pattern_src #(
    .WIDTH(WIDTH), .LEN_W(LEN_W), .HOLD_W(HOLD_W), .INIT(INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .pat_in(pat_in), .len_in(len_in),
    .hold_in(hold_in), .start(start), .stop(stop), .repeat_en(repeat_en),
    .y(y), .busy(busy), .done(done), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of expected per-cycle outputs for the active run.
  typedef struct {
    logic y;
    int   idx;
  } ent_t;

  ent_t             q[$];
  logic [WIDTH-1:0] m_pat;
  int               m_len;
  int               m_hold;
  bit               m_run;
  bit               m_fin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pat = '0;
    m_len = 0;
    m_hold = 0;
    m_run = 1'b0;
    m_fin = 1'b0;
    q.delete();
  endtask

  task automatic refill();
    ent_t e;
    for (int i = 0; i < m_len; i++) begin
      for (int h = 0; h <= m_hold; h++) begin
        e.y = m_pat[i];
        e.idx = i;
        q.push_back(e);
      end
    end
  endtask

  task automatic model_step();
    if (m_run) begin
      if (stop) begin
        m_run = 1'b0;
        q.delete();
      end else begin
        q.delete(0);
        if (q.size() == 0) begin
          if (repeat_en) refill();
          else begin
            m_run = 1'b0;
            m_fin = 1'b1;
          end
        end
      end
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else begin
      if (load) begin
        m_pat  = pat_in;
        m_len  = (int'(len_in) > WIDTH) ? WIDTH : int'(len_in);
        m_hold = int'(hold_in);
      end
      if (start && m_len > 0) begin
        refill();
        m_run = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic ey;
    int   ei;
    ey = m_run ? q[0].y : INIT;
    ei = m_run ? q[0].idx : 0;
    chk({tag, "_y"}, 32'(y), 32'(ey));
    chk({tag, "_busy"}, 32'(busy), 32'(m_run));
    chk({tag, "_done"}, 32'(done), 32'(m_fin));
    chk({tag, "_idx"}, 32'(bit_idx), 32'(ei));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_outputs("cyc");
  endtask

  task automatic set_load(input logic [WIDTH-1:0] p, input int l, input int h, input logic s);
    pat_in  = p;
    len_in  = LEN_W'(l);
    hold_in = HOLD_W'(h);
    load    = 1'b1;
    start   = s;
  endtask

  task automatic clear_ctl();
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] os_exp;
    logic [WIDTH-1:0] pat_a;
    int busycnt;

    model_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Reset while running
    set_load(16'b1011, 4, 0, 1'b1);
    step();
    clear_ctl();
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midrst");
    step();
    rst_n = 1'b1;
    step();

    // One-shot playback
    os_exp = 4'b1011;
    set_load(16'b1011, 4, 0, 1'b1);
    step();
    clear_ctl();
    chk("os_y0", 32'(y), 32'(os_exp[0]));
    for (int k = 1; k < 4; k++) begin
      step();
      chk("os_y", 32'(y), 32'(os_exp[k]));
    end
    step();
    chk("os_done", 32'(done), 32'd1);
    chk("os_y_init", 32'(y), 32'(INIT));
    step();
    chk("os_done_off", 32'(done), 32'd0);

    // Hold and repeat: 1,1,1,0,0,0,1,1,1,...
    repeat_en = 1'b1;
    set_load(16'b01, 2, 2, 1'b1);
    step();
    clear_ctl();
    chk("rep_y0", 32'(y), 32'd1);
    for (int k = 1; k < 15; k++) begin
      step();
      chk("rep_y", 32'(y), (((k / 3) % 2) == 0) ? 32'd1 : 32'd0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat_en = 1'b0;
    step();

    // Stop on the terminal cycle of the final bit
    set_load(16'h0006, 3, 1, 1'b1);
    step();
    clear_ctl();
    for (int k = 1; k <= 5; k++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stp_busy", 32'(busy), 32'd0);
    step();
    chk("stp_done", 32'(done), 32'd0);

    // Length clamp: 31 requested, 16 played
    set_load(16'(($urandom)), 31, 0, 1'b1);
    step();
    clear_ctl();
    busycnt = 1;
    repeat (20) begin
      step();
      if (busy) busycnt++;
    end
    chk("clamp_len", 32'(busycnt), 32'd16);

    // Zero length is ignored
    set_load(16'hFFFF, 0, 0, 1'b1);
    step();
    clear_ctl();
    chk("zero_busy", 32'(busy), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_y", 32'(y), 32'(INIT));

    // Load during RUN is ignored, now and for the next run
    pat_a = 16'h0005;
    set_load(pat_a, 3, 0, 1'b1);
    step();
    clear_ctl();
    set_load(16'hFFFF, 8, 0, 1'b0);
    step();
    clear_ctl();
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_y0", 32'(y), 32'(pat_a[0]));
    step();
    chk("ign_y1", 32'(y), 32'(pat_a[1]));
    repeat (4) step();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      load      = ($urandom % 4) == 0;
      start     = ($urandom % 3) == 0;
      stop      = ($urandom % 24) == 0;
      repeat_en = ($urandom % 2) == 1;
      pat_in    = 16'($urandom);
      len_in    = LEN_W'($urandom_range(0, 20));
      hold_in   = HOLD_W'($urandom_range(0, 3));
      if (($urandom % 150) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rnd_rst");
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    clear_ctl();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/digi_pattern_src.md
Name: digi_pattern_src

Overview:
- Clocked digital stimulus source; drives one logic-level bit stream into the gate-level logic devices (AND/NAND/OR/XOR/Inv inputs).
- Plays a loaded bit pattern LSB-first, holding each bit for a programmable number of clocks.
- Supports one-shot and repeat modes, with run/stop control and a completion pulse.
- Sits directly upstream of the two-input/one-input gate subcircuits, replacing ad-hoc per-gate stimulus.

Parameters:
- WIDTH, 16, maximum pattern length in bits.
- LEN_W, 5, width of the length field; must hold the value WIDTH.
- HOLD_W, 8, width of the per-bit hold counter.
- INIT, 1'b0, output level when idle, in reset, or after stop.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  capture pat_in/len_in/hold_in; honoured only in IDLE.
- pat_in  in  WIDTH  pattern; bit 0 is played first.
- len_in  in  LEN_W  number of bits to play; values above WIDTH clamp to WIDTH.
- hold_in  in  HOLD_W  each bit lasts hold+1 clocks.
- start  in  1  begin playback; honoured only in IDLE.
- stop  in  1  abort playback.
- repeat_en  in  1  wrap to bit 0 instead of finishing.
- y  out  1  logic stream to the downstream gate input.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on natural completion.
- bit_idx  out  LEN_W  index of the bit currently driven.

Behaviour:
- Reset (async assert, sync-free deassert):
  - y=INIT, busy=0, done=0, bit_idx=0, state=IDLE.
  - Stored pattern=0, len=0, hold=0.
- States: IDLE, RUN, FIN.
- IDLE:
  - y=INIT, busy=0.
  - load=1 registers pattern, clamped len and hold at the clock edge.
  - load and start in the same cycle: start uses the newly loaded values.
  - start=1 with effective len>=1 moves to RUN; start with len=0 is ignored.
- RUN entry:
  - In the first RUN cycle, y=pat[0], bit_idx=0, busy=1.
  - So y changes exactly 1 clock after the start edge.
- RUN bit timing:
  - The hold counter counts 0..hold; at hold, bit_idx advances and y=pat[bit_idx+1] on the next cycle.
  - Each bit is visible for exactly hold+1 cycles.
- End of last bit (bit_idx=len-1 and counter=hold):
  - repeat_en=1 (sampled at this edge only): bit_idx wraps to 0 with no gap cycle and no done pulse.
  - repeat_en=0: go to FIN.
- FIN: one cycle with done=1, busy=0, y=INIT; then IDLE.
- stop=1 in RUN:
  - Next cycle is IDLE, y=INIT, busy=0, done=0, bit_idx=0.
  - stop takes priority over the end-of-pattern transition in the same cycle.
- stop in IDLE or FIN: no effect; FIN still pulses done.
- load or start while RUN/FIN: ignored; stored values are unchanged during playback.
- Reset mid-RUN: immediate return to reset values; no done pulse.
- y is a registered output with no combinational path from inputs. Downstream gate threshold handling is outside this block.

Decomposition:
- Package digi_src_pkg:
  - State enum (IDLE, RUN, FIN).
  - Clamp helper for the length field.
  - Default INIT constant.
- Sub-module hold_counter:
  - Inputs: clk, rst_n, clear, enable, limit[HOLD_W-1:0].
  - Output: terminal-count flag tc.
  - Shared with the planned clock-divider source.

Test Plan:
- Reset mid-RUN: pattern 0b1011, len 4, hold 0, start at cycle 5, rst_n low at cycle 7 -> y=INIT and busy=0 immediately; done never asserted.
- One-shot:
  - Stimulus: pattern 0b1011, len 4, hold 0, start at cycle 10.
  - Response: y=1,1,0,1 on cycles 11-14; done=1 at cycle 15 only; y=0 and busy=0 from cycle 15.
- Hold and repeat:
  - Stimulus: pattern 0b01, len 2, hold 2, repeat_en=1.
  - Response: y = 1,1,1,0,0,0,1,1,1,... with no gap at the wrap and done never asserted.
- Stop priority: repeat_en=0, stop asserted on the final bit's terminal cycle -> IDLE next cycle, done stays 0.
- Clamp and zero-length:
  - len_in=31 with WIDTH=16 -> exactly 16 bits play.
  - len_in=0 then start -> busy remains 0; y=INIT.
- Ignored controls: load with new pattern 0xFFFF during RUN -> playback continues with the old pattern; a subsequent run uses the old pattern unless load is reissued in IDLE.
